layer_sched_ctrl: RTL and testbench
===================================

Name: layer_sched_ctrl

Overview:
Multi-layer scheduler for the 4-MAC systolic datapath. Holds a small per-layer descriptor table and, on start, runs each layer in order. For every layer it clears the accumulators, requests a weight load, streams the input addresses with skewed per-MAC valids, drains the array, and issues a result-store strobe. It replaces the ad-hoc start fan-out between the weight, input and valid-pipeline controllers with one FSM.

Parameters:
N_MACS, 4, number of MAC columns; width of clear/valid vectors
MAX_LAYERS, 4, descriptor table depth
ADDR_W, 8, weight/input memory address width
LEN_W, 8, per-layer stream length width
MAC_LAT, 1, MAC pipeline latency in cycles (drain term)
W_TIMEOUT, 255, max cycles to wait for w_ready

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_we  in  1  descriptor write strobe; ignored while busy
cfg_layer  in  clog2(MAX_LAYERS)  descriptor index
cfg_w_base  in  ADDR_W  weight base address for layer
cfg_in_base  in  ADDR_W  input base address for layer
cfg_len  in  LEN_W  input vectors per layer
cfg_n_layers  in  clog2(MAX_LAYERS)+1  layers to run; sampled at start
start  in  1  run request, level-sampled in IDLE
abort  in  1  synchronous abort, any state
w_ready  in  1  weight memory reports load complete
w_load  out  1  one-cycle weight-load pulse
w_addr  out  ADDR_W  weight base for current layer
in_en  out  1  input memory read enable
in_addr  out  ADDR_W  input read address
mac_valid  out  N_MACS  skewed valid; bit i = in_en delayed i cycles
clear  out  N_MACS  accumulator clear (all bits equal)
res_we  out  1  one-cycle result-capture strobe
res_layer  out  clog2(MAX_LAYERS)  layer index for res_we
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse

Behaviour:
- Reset: asynchronous and active-low on rst. The FSM goes to IDLE, the skew register and counters clear, and every output is 0. The descriptor table also resets to 0.
- All outputs are registered or Moore-decoded from state. No combinational input-to-output paths.
- IDLE: start with n_layers==0 or n_layers>MAX_LAYERS pulses err and stays in IDLE. Otherwise layer=0 and the next state is CLEAR.
- CLEAR (1 cycle): clear = all ones. If len[layer]==0, the next state is STORE. Otherwise the next state is LOAD_W.
- LOAD_W (1 cycle): w_load=1 and w_addr=w_base[layer]. w_addr holds its value until the next LOAD_W.
- WAIT_W: samples w_ready every cycle, including the first. On w_ready the next state is STREAM and k=0. If W_TIMEOUT cycles pass without w_ready, err pulses and the FSM returns to IDLE.
- STREAM (len cycles): in_en=1 and in_addr=(in_base[layer]+k) mod 2^ADDR_W, so the address wraps. After k==len-1 the next state is DRAIN.
- DRAIN: lasts N_MACS-1+MAC_LAT cycles. in_en=0 while the skew register empties.
- mac_valid: bit 0 = in_en, bit i = bit i-1 delayed by one cycle.
- STORE (1 cycle): res_we=1 and res_layer=layer. If layer+1==n_layers the next state is DONE. Otherwise layer increments and the next state is CLEAR.
- DONE (1 cycle): done=1, then IDLE.
- abort: has priority over every transition. The next state is IDLE, the skew register clears, and neither done nor err pulses. abort and start in the same cycle means abort wins.
- cfg_we while busy is dropped. A table entry written in IDLE is visible to a start in the next cycle.
- Layer timing, with start sampled at edge t, L=len and D=N_MACS-1+MAC_LAT:
  - CLEAR at cycle t+1
  - LOAD_W at t+2
  - WAIT_W at t+3
  - STREAM from t+4 to t+3+L
  - DRAIN for D cycles after STREAM
  - STORE after DRAIN
  - DONE after the last layer's STORE

Decomposition:
- Package layer_sched_pkg holds:
  - state enum: IDLE, CLEAR, LOAD_W, WAIT_W, STREAM, DRAIN, STORE, DONE
  - descriptor struct {w_base, in_base, len}
  - DRAIN_CYC = N_MACS-1+MAC_LAT
- Sub-module valid_skew: an N_MACS-deep shift register with a synchronous flush. It generates mac_valid from in_en.

Test Plan:
- One layer, default parameters, w_base=0x10, in_base=0x20, len=8, w_ready tied high:
  - clear at t+1, w_load at t+2 with w_addr=0x10, in_en from t+4 to t+11 with in_addr 0x20..0x27
  - mac_valid[3] high from t+7 to t+14, res_we at t+16, done at t+17
- Three layers with lens 2,0,3: three res_we pulses with res_layer 0,1,2. Layer 1 shows clear then res_we with no w_load and no in_en. done pulses once.
- in_base=0xFE, len=4: in_addr sequence is 0xFE, 0xFF, 0x00, 0x01.
- w_ready never asserted: err pulses exactly W_TIMEOUT cycles after WAIT_W entry. The FSM returns to IDLE with no res_we and no done.
- abort in the third STREAM cycle:
  - next cycle: busy=0, in_en=0, mac_valid cleared
  - no done or err pulse
  - a fresh start then runs the layer normally
- Boundary checks:
  - start with n_layers=0 gives an err pulse and no busy.
  - cfg_we while busy leaves the table unchanged on the next run.
  - Asserting rst low mid-STREAM zeroes all outputs immediately.

Source files
------------

// File: rtl/layer_sched_pkg.sv
// Shared types and constants for the multi-layer scheduler.
package layer_sched_pkg;

  localparam int DEF_N_MACS  = 4;
  localparam int DEF_MAC_LAT = 1;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LEN_W   = 8;

  // FSM state encoding, kept as plain constants so older tools can read it.
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t CLEAR  = 3'd1;
  localparam state_t LOAD_W = 3'd2;
  localparam state_t WAIT_W = 3'd3;
  localparam state_t STREAM = 3'd4;
  localparam state_t DRAIN  = 3'd5;
  localparam state_t STORE  = 3'd6;
  localparam state_t DONE   = 3'd7;

  // One entry of the per-layer descriptor table.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] w_base;
    logic [DEF_ADDR_W-1:0] in_base;
    logic [DEF_LEN_W-1:0]  len;
  } desc_t;

  // Cycles needed after the last input for the skewed valid to leave the array.
  function automatic int drain_cycles(input int n_macs, input int mac_lat);
    return n_macs - 1 + mac_lat;
  endfunction

  localparam int DRAIN_CYC = drain_cycles(DEF_N_MACS, DEF_MAC_LAT);

endpackage

// File: rtl/valid_skew.sv
// Shift register that turns the input-enable level into per-MAC skewed valids.
module valid_skew #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         din,
  output logic [N-1:0] q
);

  logic [N-1:0] shift_in;

  assign shift_in[0] = din;

  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_tap
      assign shift_in[gi] = q[gi-1];
    end
  endgenerate

  // Advance every stage by one column; flush empties the whole chain at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else begin
      q <= shift_in;
    end
  end

endmodule

// File: rtl/layer_sched_ctrl.sv
// Runs each configured layer through clear, weight load, stream, drain and store.
module layer_sched_ctrl
  import layer_sched_pkg::*;
#(
  parameter int N_MACS     = DEF_N_MACS,
  parameter int MAX_LAYERS = 4,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int MAC_LAT    = DEF_MAC_LAT,
  parameter int W_TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_layer,
  input  logic [ADDR_W-1:0]             cfg_w_base,
  input  logic [ADDR_W-1:0]             cfg_in_base,
  input  logic [LEN_W-1:0]              cfg_len,
  input  logic [$clog2(MAX_LAYERS):0]   cfg_n_layers,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          w_ready,
  output logic                          w_load,
  output logic [ADDR_W-1:0]             w_addr,
  output logic                          in_en,
  output logic [ADDR_W-1:0]             in_addr,
  output logic [N_MACS-1:0]             mac_valid,
  output logic [N_MACS-1:0]             clear,
  output logic                          res_we,
  output logic [$clog2(MAX_LAYERS)-1:0] res_layer,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int LAYER_W = $clog2(MAX_LAYERS);
  localparam int DRAIN_N = drain_cycles(N_MACS, MAC_LAT);
  localparam int CNT_W   = $clog2((W_TIMEOUT > DRAIN_N ? W_TIMEOUT : DRAIN_N) + 1);
  localparam logic [LAYER_W:0] MAX_N     = (LAYER_W + 1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0] ONE_N     = (LAYER_W + 1)'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(W_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(DRAIN_N - 1);

  desc_t               tbl_reg [MAX_LAYERS];
  state_t              state_reg, state_next;
  logic [LAYER_W-1:0]  layer_reg, layer_next;
  logic [LAYER_W:0]    n_layers_reg, n_layers_next;
  logic [LEN_W-1:0]    k_reg, k_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                err_next;
  logic                stream_next;
  logic [LEN_W-1:0]    cur_len;
  logic [ADDR_W-1:0]   next_w_base, next_in_base;

  assign cur_len      = tbl_reg[layer_reg].len;
  assign next_w_base  = tbl_reg[layer_next].w_base;
  assign next_in_base = tbl_reg[layer_next].in_base;
  assign stream_next  = (state_next == STREAM);

  // Descriptor table: writable only while idle so a running job sees a stable table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LAYERS; i++) tbl_reg[i] <= '0;
    end else if (cfg_we && state_reg == IDLE) begin
      tbl_reg[cfg_layer] <= '{w_base: cfg_w_base, in_base: cfg_in_base, len: cfg_len};
    end
  end

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_next    = state_reg;
    layer_next    = layer_reg;
    n_layers_next = n_layers_reg;
    k_next        = k_reg;
    cnt_next      = cnt_reg;
    err_next      = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          if (cfg_n_layers == '0 || cfg_n_layers > MAX_N) begin
            err_next = 1'b1;
          end else begin
            n_layers_next = cfg_n_layers;
            layer_next    = '0;
            state_next    = CLEAR;
          end
        end
        CLEAR:  state_next = (cur_len == '0) ? STORE : LOAD_W;
        LOAD_W: begin
          state_next = WAIT_W;
          cnt_next   = '0;
        end
        WAIT_W: begin
          if (w_ready) begin
            state_next = STREAM;
            k_next     = '0;
          end else if (cnt_reg == WAIT_LAST) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        STREAM: begin
          if (k_reg == cur_len - LEN_W'(1)) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            k_next = k_reg + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_reg == DRN_LAST) state_next = STORE;
          else cnt_next = cnt_reg + CNT_W'(1);
        end
        STORE: begin
          if ({1'b0, layer_reg} + ONE_N == n_layers_reg) begin
            state_next = DONE;
          end else begin
            layer_next = layer_reg + LAYER_W'(1);
            state_next = CLEAR;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, counters and all outputs are registered from the next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      layer_reg    <= '0;
      n_layers_reg <= '0;
      k_reg        <= '0;
      cnt_reg      <= '0;
      clear        <= '0;
      w_load       <= 1'b0;
      w_addr       <= '0;
      in_addr      <= '0;
      res_we       <= 1'b0;
      res_layer    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_reg    <= state_next;
      layer_reg    <= layer_next;
      n_layers_reg <= n_layers_next;
      k_reg        <= k_next;
      cnt_reg      <= cnt_next;
      clear        <= {N_MACS{state_next == CLEAR}};
      w_load       <= (state_next == LOAD_W);
      if (state_next == LOAD_W) w_addr <= next_w_base;
      in_addr      <= stream_next ? next_in_base + ADDR_W'(k_next) : '0;
      res_we       <= (state_next == STORE);
      if (state_next == STORE) res_layer <= layer_next;
      busy         <= (state_next != IDLE);
      done         <= (state_next == DONE);
      err          <= err_next;
    end
  end

  // Column 0 of the skew chain doubles as the registered input enable.
  valid_skew #(.N(N_MACS)) u_skew (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .din   (stream_next),
    .q     (mac_valid)
  );

  assign in_en = mac_valid[0];

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Directed and randomized checks of layer_sched_ctrl against an event-level model.
module tb_layer_sched_ctrl;

  localparam int N_MACS = 4, MAX_LAYERS = 4, ADDR_W = 8, LEN_W = 8, MAC_LAT = 1, W_TIMEOUT = 255;
  localparam int D  = N_MACS - 1 + MAC_LAT;
  localparam int NK = 7;  // event kinds: clear, w_load, in_en, mac_valid, res_we, done, err

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 0, start = 0, abort = 0, w_ready = 0;
  logic [1:0] cfg_layer = '0;
  logic [ADDR_W-1:0] cfg_w_base = '0, cfg_in_base = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [2:0] cfg_n_layers = '0;
  logic w_load, in_en, res_we, busy, done, err;
  logic [ADDR_W-1:0] w_addr, in_addr;
  logic [N_MACS-1:0] mac_valid, clear;
  logic [1:0] res_layer;

  always #5 clk = ~clk;

  layer_sched_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_w_base(cfg_w_base),
    .cfg_in_base(cfg_in_base), .cfg_len(cfg_len), .cfg_n_layers(cfg_n_layers), .start(start),
    .abort(abort), .w_ready(w_ready), .w_load(w_load), .w_addr(w_addr), .in_en(in_en),
    .in_addr(in_addr), .mac_valid(mac_valid), .clear(clear), .res_we(res_we),
    .res_layer(res_layer), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed { int cyc; int val; } ev_t;
  ev_t act_q [NK][$];
  ev_t exp_q [NK][$];
  int cyc = 0, busy_cnt = 0, exp_busy = 0, last_t0 = 0;
  int total = 0, bad = 0;
  int sh_w [MAX_LAYERS], sh_in [MAX_LAYERS], sh_len [MAX_LAYERS];

  function automatic ev_t mk(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  function automatic string kname(input int k);
    case (k)
      0: return "clear";
      1: return "w_load";
      2: return "in_en";
      3: return "mac_valid";
      4: return "res_we";
      5: return "done";
      default: return "err";
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return {w_load, w_addr, in_en, in_addr, mac_valid, clear, res_we, res_layer, busy, done, err};
  endfunction

  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output event away from the active edge.
  always @(negedge clk) begin
    if (clear != 0)     act_q[0].push_back(mk(cyc, int'(clear)));
    if (w_load)         act_q[1].push_back(mk(cyc, int'(w_addr)));
    if (in_en)          act_q[2].push_back(mk(cyc, int'(in_addr)));
    if (mac_valid != 0) act_q[3].push_back(mk(cyc, int'(mac_valid)));
    if (res_we)         act_q[4].push_back(mk(cyc, int'(res_layer)));
    if (done)           act_q[5].push_back(mk(cyc, 1));
    if (err)            act_q[6].push_back(mk(cyc, 1));
    if (busy)           busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected event timeline derived from the layer timing rules (start presented in cycle t0).
  task automatic build_exp(input int t0, input int n, input bit wr);
    int c;
    bit stopped;
    bit [3:0] mv [int];
    for (int k = 0; k < NK; k++) exp_q[k].delete();
    stopped = 0;
    if (n == 0 || n > MAX_LAYERS) begin
      exp_q[6].push_back(mk(t0 + 1, 1));
      exp_busy = 0;
      return;
    end
    c = t0 + 1;
    for (int l = 0; l < n && !stopped; l++) begin
      exp_q[0].push_back(mk(c, (1 << N_MACS) - 1));
      if (sh_len[l] == 0) begin
        exp_q[4].push_back(mk(c + 1, l));
        c += 2;
      end else begin
        exp_q[1].push_back(mk(c + 1, sh_w[l]));
        if (!wr) begin
          exp_q[6].push_back(mk(c + 2 + W_TIMEOUT, 1));
          exp_busy = c + 1 + W_TIMEOUT - t0;
          stopped = 1;
        end else begin
          for (int k = 0; k < sh_len[l]; k++) begin
            exp_q[2].push_back(mk(c + 3 + k, (sh_in[l] + k) % 256));
            for (int i = 0; i < N_MACS; i++) begin
              if (mv.exists(c + 3 + k + i)) mv[c + 3 + k + i] = mv[c + 3 + k + i] | 4'(1 << i);
              else mv[c + 3 + k + i] = 4'(1 << i);
            end
          end
          exp_q[4].push_back(mk(c + 3 + sh_len[l] + D, l));
          c += 4 + sh_len[l] + D;
        end
      end
    end
    foreach (mv[x]) exp_q[3].push_back(mk(x, int'(mv[x])));
    if (!stopped) begin
      exp_q[5].push_back(mk(c, 1));
      exp_busy = c - t0;
    end
  endtask

  task automatic compare(input string name);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("%s_%s_count", name, kname(k)), act_q[k].size(), exp_q[k].size());
      for (int i = 0; i < act_q[k].size() && i < exp_q[k].size(); i++) begin
        chk($sformatf("%s_%s%0d_cycle", name, kname(k), i), act_q[k][i].cyc - last_t0, exp_q[k][i].cyc - last_t0);
        chk($sformatf("%s_%s%0d_value", name, kname(k), i), act_q[k][i].val, exp_q[k][i].val);
      end
    end
    chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  task automatic cfg_write(input int l, input int wb, input int ib, input int len);
    @(negedge clk);
    cfg_we = 1; cfg_layer = 2'(l); cfg_w_base = 8'(wb); cfg_in_base = 8'(ib); cfg_len = 8'(len);
    @(negedge clk);
    cfg_we = 0;
    sh_w[l] = wb & 255; sh_in[l] = ib & 255; sh_len[l] = len & 255;
  endtask

  // Start a job, optionally attempt a table write while busy, then check the whole timeline.
  task automatic run(input string name, input int n, input bit wr, input bit junk);
    bit fin;
    for (int k = 0; k < NK; k++) act_q[k].delete();
    w_ready = wr;
    cfg_n_layers = 3'(n);
    @(negedge clk);
    last_t0 = cyc; busy_cnt = 0; start = 1;
    build_exp(last_t0, n, wr);
    @(negedge clk);
    start = 0;
    fin = 0;
    for (int i = 0; i < 1000 && !fin; i++) begin
      if (junk && cyc == last_t0 + 3) begin
        cfg_we = 1; cfg_layer = 0; cfg_w_base = 8'hAA; cfg_in_base = 8'h55; cfg_len = 8'd1;
      end else begin
        cfg_we = 0;
      end
      @(negedge clk);
      fin = (act_q[5].size() > 0) || (act_q[6].size() > 0);
    end
    cfg_we = 0;
    chk({name, "_finished"}, fin, 1);
    repeat (6) @(negedge clk);
    compare(name);
  endtask

  initial begin
    int first_mv3, n_rand;
    for (int i = 0; i < MAX_LAYERS; i++) begin sh_w[i] = 0; sh_in[i] = 0; sh_len[i] = 0; end
    #2 rst = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single layer, reference timeline
    cfg_write(0, 'h10, 'h20, 8);
    run("one_layer", 1, 1, 0);
    chk("one_layer_res_offset", act_q[4].size() > 0 ? act_q[4][0].cyc - last_t0 : -1, 16);
    chk("one_layer_done_offset", act_q[5].size() > 0 ? act_q[5][0].cyc - last_t0 : -1, 17);
    first_mv3 = -1;
    foreach (act_q[3][i]) if (first_mv3 < 0 && act_q[3][i].val[3]) first_mv3 = act_q[3][i].cyc - last_t0;
    chk("one_layer_mv3_first", first_mv3, 7);

    // Three layers with an empty middle layer
    cfg_write(0, 'h31, 'h40, 2);
    cfg_write(1, 'h32, 'h50, 0);
    cfg_write(2, 'h33, 'h60, 3);
    run("three_layers", 3, 1, 0);
    chk("three_layers_wload_count", act_q[1].size(), 2);

    // Input address wrap
    cfg_write(0, 'h07, 'hFE, 4);
    run("addr_wrap", 1, 1, 0);

    // Illegal layer counts
    run("n_zero", 0, 1, 0);
    run("n_too_big", 5, 1, 0);

    // Weight-load timeout
    run("w_timeout", 1, 0, 0);
    chk("w_timeout_no_store", act_q[4].size(), 0);

    // Abort in the third stream cycle, then a clean rerun
    cfg_write(0, 'h44, 'h80, 6);
    for (int k = 0; k < NK; k++) act_q[k].delete();
    w_ready = 1; cfg_n_layers = 1;
    @(negedge clk);
    last_t0 = cyc; start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < last_t0 + 6) @(negedge clk);
    chk("abort_pre_in_addr", in_addr, 8'h82);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_en", in_en, 0);
    chk("abort_mac_valid", mac_valid, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", act_q[5].size(), 0);
    chk("abort_no_err", act_q[6].size(), 0);
    chk("abort_no_store", act_q[4].size(), 0);
    run("after_abort", 1, 1, 0);

    // abort and start together: abort wins
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_clear", clear, 0);

    // Table write while busy is dropped
    cfg_write(0, 'h12, 'h34, 5);
    run("busy_write", 1, 1, 1);
    run("busy_write_rerun", 1, 1, 0);

    // Randomized multi-layer jobs
    for (int r = 0; r < 5; r++) begin
      for (int l = 0; l < MAX_LAYERS; l++)
        cfg_write(l, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 10)));
      n_rand = int'($urandom_range(1, MAX_LAYERS));
      run($sformatf("rand%0d", r), n_rand, 1, 0);
    end

    // Reset in the middle of streaming
    cfg_write(0, 'h21, 'h22, 8);
    cfg_n_layers = 1; w_ready = 1;
    @(negedge clk);
    last_t0 = cyc; start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < last_t0 + 5) @(negedge clk);
    chk("pre_reset_in_en", in_en, 1);
    rst = 0;
    #1;
    chk("mid_reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < MAX_LAYERS; i++) begin sh_w[i] = 0; sh_in[i] = 0; sh_len[i] = 0; end
    run("after_reset", 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
